// File: rtl/oldland_lsu.sv
// oldland_lsu: load/store unit bridging the execute stage to a single-beat data bus
module oldland_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [3:0]  rd_sel,
  input  logic        i_valid,
  output logic [29:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  output logic        d_access,
  input  logic [31:0] d_data,
  input  logic        d_ack,
  input  logic        d_error,
  output logic [31:0] reg_wr_val,
  output logic [3:0]  reg_wr_sel,
  output logic        reg_wr_en,
  output logic        busy,
  output logic        data_abort,
  output logic        i_valid_out
);
  typedef enum logic [1:0] {IDLE, BUS, COMPLETE} state_t;
  state_t state_q, state_d;
  logic [29:0] d_addr_q, d_addr_d;
  logic [3:0]  d_bytesel_q, d_bytesel_d;
  logic [31:0] d_wr_val_q, d_wr_val_d;
  logic        d_wr_en_q, d_wr_en_d;
  logic        d_access_q, d_access_d;
  logic [31:0] reg_wr_val_q, reg_wr_val_d;
  logic [3:0]  reg_wr_sel_q, reg_wr_sel_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        busy_q, busy_d;
  logic        data_abort_q, data_abort_d;
  logic        i_valid_out_q, i_valid_out_d;
  logic [3:0]  rd_q, rd_d;
  logic        st_q, st_d;
  logic [1:0]  wid_q, wid_d;
  logic [1:0]  lane_q, lane_d;
  logic        req, mis;
  logic [3:0]  bsel;
  logic [31:0] wv, sh, ld;
  assign d_addr      = d_addr_q;
  assign d_bytesel   = d_bytesel_q;
  assign d_wr_val    = d_wr_val_q;
  assign d_wr_en     = d_wr_en_q;
  assign d_access    = d_access_q;
  assign reg_wr_val  = reg_wr_val_q;
  assign reg_wr_sel  = reg_wr_sel_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign busy        = busy_q;
  assign data_abort  = data_abort_q;
  assign i_valid_out = i_valid_out_q;
  // Request decode: alignment, lane enables, replicated store data and load extraction
  always_comb begin
    req  = mem_load | mem_store;
    mis  = (mem_width == 2'b11) | (mem_width == 2'b01 & mar[0]) | (mem_width == 2'b10 & mar[1:0] != 2'b00);
    bsel = mem_width == 2'b00 ? 4'b0001 << mar[1:0] : mem_width == 2'b01 ? (mar[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wv   = mem_width == 2'b00 ? {4{mdr[7:0]}} : mem_width == 2'b01 ? {2{mdr[15:0]}} : mdr;
    sh   = d_data >> {lane_q, 3'b000};
    ld   = wid_q == 2'b00 ? {24'b0, sh[7:0]} : wid_q == 2'b01 ? {16'b0, lane_q[1] ? d_data[31:16] : d_data[15:0]} : d_data;
  end
  // Next-state and next-output logic; pulses default low, bus fields hold
  always_comb begin
    state_d       = state_q;
    d_addr_d      = d_addr_q;
    d_bytesel_d   = d_bytesel_q;
    d_wr_val_d    = d_wr_val_q;
    d_wr_en_d     = d_wr_en_q;
    d_access_d    = d_access_q;
    reg_wr_val_d  = reg_wr_val_q;
    reg_wr_sel_d  = reg_wr_sel_q;
    reg_wr_en_d   = 1'b0;
    busy_d        = busy_q;
    data_abort_d  = 1'b0;
    i_valid_out_d = 1'b0;
    rd_d          = rd_q;
    st_d          = st_q;
    wid_d         = wid_q;
    lane_d        = lane_q;
    case (state_q)
      IDLE: begin
        if (!req) begin
          reg_wr_val_d  = wr_val;
          reg_wr_sel_d  = rd_sel;
          reg_wr_en_d   = wr_result;
          i_valid_out_d = i_valid;
        end else if (mis) begin
          data_abort_d = 1'b1;
        end else begin
          state_d     = BUS;
          d_access_d  = 1'b1;
          busy_d      = 1'b1;
          d_wr_en_d   = mem_store;
          d_addr_d    = mar[31:2];
          d_bytesel_d = bsel;
          d_wr_val_d  = wv;
          rd_d        = rd_sel;
          st_d        = mem_store;
          wid_d       = mem_width;
          lane_d      = mar[1:0];
        end
      end
      BUS: begin
        if (d_error) begin
          state_d      = IDLE;
          d_access_d   = 1'b0;
          d_wr_en_d    = 1'b0;
          busy_d       = 1'b0;
          data_abort_d = 1'b1;
        end else if (d_ack) begin
          state_d       = COMPLETE;
          d_access_d    = 1'b0;
          d_wr_en_d     = 1'b0;
          reg_wr_en_d   = !st_q;
          reg_wr_sel_d  = rd_q;
          reg_wr_val_d  = st_q ? reg_wr_val_q : ld;
          i_valid_out_d = 1'b1;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers with synchronous reset aborting any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      d_addr_q      <= '0;
      d_bytesel_q   <= '0;
      d_wr_val_q    <= '0;
      d_wr_en_q     <= 1'b0;
      d_access_q    <= 1'b0;
      reg_wr_val_q  <= '0;
      reg_wr_sel_q  <= '0;
      reg_wr_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      data_abort_q  <= 1'b0;
      i_valid_out_q <= 1'b0;
      rd_q          <= '0;
      st_q          <= 1'b0;
      wid_q         <= '0;
      lane_q        <= '0;
    end else begin
      state_q       <= state_d;
      d_addr_q      <= d_addr_d;
      d_bytesel_q   <= d_bytesel_d;
      d_wr_val_q    <= d_wr_val_d;
      d_wr_en_q     <= d_wr_en_d;
      d_access_q    <= d_access_d;
      reg_wr_val_q  <= reg_wr_val_d;
      reg_wr_sel_q  <= reg_wr_sel_d;
      reg_wr_en_q   <= reg_wr_en_d;
      busy_q        <= busy_d;
      data_abort_q  <= data_abort_d;
      i_valid_out_q <= i_valid_out_d;
      rd_q          <= rd_d;
      st_q          <= st_d;
      wid_q         <= wid_d;
      lane_q        <= lane_d;
    end
  end
endmodule

// File: doc/oldland_lsu.md
OLDLAND_LSU -- requirements
Module: oldland_lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these execute-side inputs:
- mem_load  in  1  load request this cycle.
- mem_store  in  1  store request this cycle.
- mem_width  in  2  access width: 00 byte, 01 half, 10 word; 11 reserved.
- mar  in  32  byte address.
- mdr  in  32  store data, LSBs valid.
- wr_val  in  32  non-memory writeback value.
- wr_result  in  1  writeback requested.
- rd_sel  in  4  destination register.
- i_valid  in  1  instruction valid.
REQ-003 The block SHALL have these bus-side ports:
- d_addr  out  30  word address (mar[31:2]).
- d_bytesel  out  4  byte lane enables.
- d_wr_val  out  32  write data.
- d_wr_en  out  1  write cycle.
- d_access  out  1  bus request.
- d_data  in  32  read data.
- d_ack  in  1  transfer complete.
- d_error  in  1  bus fault.
REQ-004 The block SHALL have these writeback and control outputs:
- reg_wr_val  out  32  writeback data.
- reg_wr_sel  out  4  writeback register.
- reg_wr_en  out  1  writeback strobe.
- busy  out  1  pipeline stall request.
- data_abort  out  1  one-cycle fault pulse.
- i_valid_out  out  1  instruction retired.

Function
REQ-005 The FSM SHALL have states IDLE, BUS and COMPLETE.
REQ-006 In IDLE with neither mem_load nor mem_store, the block SHALL register reg_wr_val=wr_val, reg_wr_sel=rd_sel, reg_wr_en=wr_result and i_valid_out=i_valid, with 1-cycle latency.
REQ-007 In IDLE with mem_load or mem_store and an aligned address, the block SHALL latch the address, width, mdr, rd_sel and direction, enter BUS, and assert d_access, busy and d_wr_en (store only) from the next cycle.
REQ-008 Alignment: a half access with mar[0]=1, a word access with mar[1:0]!=00, or mem_width=11 SHALL be misaligned; the block SHALL then issue no bus cycle, pulse data_abort for one cycle, keep reg_wr_en=0 and i_valid_out=0, and remain in IDLE.
REQ-009 d_bytesel SHALL be: byte 0001<<mar[1:0]; half 0011 when mar[1]=0, else 1100; word 1111.
REQ-010 d_wr_val SHALL be: byte {4{mdr[7:0]}}; half {2{mdr[15:0]}}; word mdr.
REQ-011 d_access, d_addr, d_bytesel, d_wr_val and d_wr_en SHALL stay stable in BUS until the cycle d_ack or d_error is sampled high.
REQ-012 On d_ack in BUS, the block SHALL drop d_access next cycle and enter COMPLETE.
REQ-013 For a load, the block SHALL capture d_data on the ack edge and zero-extend it: byte d_data[8*a+7:8*a] with a=mar[1:0]; half d_data[31:16] when mar[1]=1, else d_data[15:0].
REQ-014 In COMPLETE, the block SHALL pulse reg_wr_en=1 for loads (0 for stores) with reg_wr_sel equal to the latched rd_sel, pulse i_valid_out, deassert busy, and return to IDLE.
REQ-015 COMPLETE SHALL not accept a new request; inputs are ignored whenever state != IDLE.
REQ-016 On d_error in BUS (including d_error and d_ack in the same cycle), the block SHALL treat error as winning: pulse data_abort next cycle, drop d_access, write back nothing, and return to IDLE.
REQ-017 busy SHALL be high in BUS and COMPLETE and low in IDLE; a load or store therefore occupies at least 3 cycles (request, BUS, COMPLETE).
REQ-018 d_ack or d_error sampled outside BUS SHALL be ignored.
REQ-019 Simultaneous mem_load and mem_store SHALL be treated as a store.

Reset
REQ-020 On rst, the block SHALL enter IDLE and clear d_access, d_wr_en, d_bytesel, reg_wr_en, reg_wr_sel, reg_wr_val, busy, data_abort and i_valid_out to 0 at the next edge, aborting any transfer in progress.
REQ-021 After reset, an ack arriving for the aborted transfer SHALL be ignored, and no writeback or abort SHALL result.

Verification
REQ-022 Word load: mar=0x1000, width=10, d_ack one cycle after d_access, d_data=0xDEADBEEF -> one reg_wr_en pulse, reg_wr_val=0xDEADBEEF, reg_wr_sel=rd_sel, busy high 2 cycles.
REQ-023 Byte store: mar=0x1003, mdr=0x000000A5 -> d_bytesel=1000, d_wr_val=0xA5A5A5A5, d_wr_en=1, d_addr=0x400; no reg_wr_en.
REQ-024 Half load: mar=0x2002, d_data=0x12345678 -> reg_wr_val=0x00001234; with 3-cycle ack delay, d_access is held 3 cycles with stable d_addr.
REQ-025 Misaligned: word load at mar=0x1001 -> d_access never asserted, data_abort pulse 1 cycle, no writeback.
REQ-026 Bus error: load with d_error and d_ack in the same cycle -> data_abort pulse, reg_wr_en stays 0, FSM returns to IDLE.
REQ-027 Reset mid-BUS, then an ack 2 cycles later -> all outputs 0, no writeback; a subsequent load completes normally.
